// File: rtl/nibble_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
// A zero divisor skips iteration and reports all-ones quotient with div_by_zero after one cycle.
module nibble_divider #(
   parameter int unsigned DW = 8,
   parameter int unsigned VW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] quotient,
   output logic [VW-1:0] remainder,
   output logic          div_by_zero
);

   localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

   // StZero is the one internal cycle that resolves a zero divisor; busy stays low there.
   typedef enum logic [1:0] {StIdle, StRun, StZero, StDone} state_e;

   state_e        state_q, state_d;
   logic [DW-1:0] shift_q, shift_d;
   logic [VW-1:0] divr_q, divr_d;
   logic [VW:0]   part_q, part_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] quot_q, quot_d;
   logic [VW-1:0] rem_q, rem_d;
   logic          dbz_q, dbz_d;

   logic [VW:0]   p;
   logic [VW:0]   p_sub;
   logic          q_bit;

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      divr_d  = divr_q;
      part_d  = part_q;
      cnt_d   = cnt_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;

      p     = {part_q[VW-1:0], shift_q[DW-1]};
      p_sub = p - {1'b0, divr_q};
      q_bit = (p >= {1'b0, divr_q});

      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               shift_d = dividend;
               divr_d  = divisor;
               part_d  = '0;
               cnt_d   = '0;
               dbz_d   = 1'b0;
               state_d = (divisor == '0) ? StZero : StRun;
            end else if (state_q == StDone) begin
               state_d = StIdle;
            end
         end
         StRun: begin
            part_d  = q_bit ? p_sub : p;
            shift_d = {shift_q[DW-2:0], q_bit};
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CW'(DW - 1)) begin
               quot_d  = {shift_q[DW-2:0], q_bit};
               rem_d   = q_bit ? p_sub[VW-1:0] : p[VW-1:0];
               state_d = StDone;
            end
         end
         StZero: begin
            quot_d  = '1;
            rem_d   = '0;
            dbz_d   = 1'b1;
            state_d = StDone;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         shift_q <= '0;
         divr_q  <= '0;
         part_q  <= '0;
         cnt_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         divr_q  <= divr_d;
         part_q  <= part_d;
         cnt_q   <= cnt_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
      end
   end

   assign busy        = (state_q == StRun);
   assign done        = (state_q == StDone);
   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_nibble_divider.sv
// Scoreboard bench for nibble_divider: driver pushes reference results, a negedge monitor checks.
module tb_nibble_divider;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] dividend;
   logic [3:0] divisor;
   logic       busy;
   logic       done;
   logic [7:0] quotient;
   logic [3:0] remainder;
   logic       div_by_zero;

   typedef struct {
      int q;
      int r;
      int z;
      int done_cyc;
      int busy_n;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   busy_cnt = 0;

   nibble_divider #(.DW(8), .VW(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: plain integer division with the zero-divisor rule.
   task automatic issue(input int a, input int b);
      exp_t e;
      e.q        = (b == 0) ? 255 : a / b;
      e.r        = (b == 0) ? 0 : a % b;
      e.z        = (b == 0) ? 1 : 0;
      e.done_cyc = cyc + 1 + ((b == 0) ? 1 : 8);
      e.busy_n   = (b == 0) ? 0 : 8;
      sb.push_back(e);
      start    = 1'b1;
      dividend = 8'(a);
      divisor  = 4'(b);
      @(negedge clk);
      start    = 1'b0;
      dividend = 8'($urandom);
      divisor  = 4'($urandom);
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!done) check("done_timeout", 0, 1);
   endtask

   task automatic do_op(input int a, input int b);
      issue(a, b);
      wait_done();
      if ($urandom_range(0, 1) == 0) begin
         repeat ($urandom_range(1, 3)) @(negedge clk);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            busy_cnt = 0;
         end else begin
            if (busy && done) check("busy_and_done", 1, 0);
            if (busy) busy_cnt++;
            if (done) begin
               if (sb.size() == 0) begin
                  check("unexpected_done", 1, 0);
               end else begin
                  exp_t e;
                  e = sb.pop_front();
                  check("quotient", int'(quotient), e.q);
                  check("remainder", int'(remainder), e.r);
                  check("div_by_zero", int'(div_by_zero), e.z);
                  check("latency", cyc, e.done_cyc);
                  check("busy_cycles", busy_cnt, e.busy_n);
               end
               busy_cnt = 0;
            end
         end
      end
   end

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_quotient", int'(quotient), 0);
      check("rst_remainder", int'(remainder), 0);
      check("rst_dbz", int'(div_by_zero), 0);
      @(negedge clk);

      do_op(200, 7);
      do_op(255, 1);
      do_op(5, 9);
      do_op(0, 15);
      do_op(100, 0);
      repeat (2) @(negedge clk);

      // Start pulsed mid-RUN must be ignored; then a back-to-back start in the DONE cycle.
      issue(200, 7);
      repeat (2) @(negedge clk);
      start    = 1'b1;
      dividend = 8'd50;
      divisor  = 4'd3;
      @(negedge clk);
      start = 1'b0;
      wait_done();
      issue(50, 3);
      wait_done();
      repeat (2) @(negedge clk);

      // Reset on RUN cycle 4 aborts the divide without a done pulse.
      issue(200, 7);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      void'(sb.pop_back());
      check("abort_busy", int'(busy), 0);
      check("abort_done", int'(done), 0);
      check("abort_quotient", int'(quotient), 0);
      check("abort_remainder", int'(remainder), 0);
      check("abort_dbz", int'(div_by_zero), 0);
      repeat (10) @(negedge clk);
      do_op(17, 4);

      for (int a = 0; a < 256; a++) begin
         for (int b = 0; b < 16; b++) begin
            do_op(a, b);
         end
      end

      for (int i = 0; i < 200; i++) begin
         do_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 15)));
      end

      repeat (12) @(negedge clk);
      check("scoreboard_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
